// File: rtl/rgb_gray_ingest.sv
// Frame ingest: groups interleaved R,G,B bytes into pixels, converts each to luma,
// and streams it through a small FWFT FIFO with frame markers. GRAY_STATS_EN adds per-frame min/max.
module rgb_gray_ingest #(
  parameter int WIDTH      = 5,
  parameter int HEIGHT     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       camera_en,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_sof,
  output logic       m_eol,
  output logic       m_eof,
  output logic       busy,
  output logic       done,
`ifdef GRAY_STATS_EN
  output logic [7:0] frame_min,
  output logic [7:0] frame_max,
`endif
  output logic       overflow
);

  // state | meaning
  // IDLE  | waiting for start
  // REQ   | camera enabled, sampling bytes into pixels
  // DRAIN | frame captured, emptying the FIFO before done
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_phase;
  logic [7:0]      r_red;
  logic [7:0]      r_green;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [10:0]     r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            r_overflow;

  logic            w_empty;
  logic            w_full;
  logic            w_byte;
  logic            w_pix;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_start_req;
  logic [15:0]     w_sum;
  logic [7:0]      w_luma;
  logic            w_sof;
  logic            w_eol;
  logic            w_eof;
  logic [10:0]     w_head;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_byte      = (r_state == S_REQ) && s_valid;
  assign w_pix       = w_byte && (r_phase == 2'd2);
  assign w_pop       = !w_empty && m_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the pixel
  assign w_push      = w_pix && (!w_full || w_pop);
  assign w_drop      = w_pix && w_full && !w_pop;
  assign w_start_req = (r_state == S_IDLE) && start;

  // Worst case 256*255+128 still fits in 16 bits
  assign w_sum  = 16'd77  * {8'd0, r_red}
                + 16'd150 * {8'd0, r_green}
                + 16'd29  * {8'd0, s_data}
                + 16'd128;
  assign w_luma = 8'(w_sum >> 8);

  assign w_sof = (r_x == '0) && (r_y == '0);
  assign w_eol = (r_x == XW'(WIDTH - 1));
  assign w_eof = w_eol && (r_y == YW'(HEIGHT - 1));

  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign m_valid  = !w_empty;
  assign m_data   = w_head[10:3];
  assign m_sof    = w_head[2];
  assign m_eol    = w_head[1];
  assign m_eof    = w_head[0];
  assign overflow = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // camera_en decodes the state register directly so reset drops it without a clock
  always_comb begin
    w_state_nxt = r_state;
    camera_en   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        camera_en = 1'b1;
        busy      = 1'b1;
        if (w_pix && w_eof) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_empty) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= 2'd0;
      r_red      <= 8'd0;
      r_green    <= 8'd0;
      r_x        <= '0;
      r_y        <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start_req) begin
        r_phase    <= 2'd0;
        r_x        <= '0;
        r_y        <= '0;
        r_overflow <= 1'b0;
      end else if (w_byte) begin
        case (r_phase)
          2'd0: begin
            r_red   <= s_data;
            r_phase <= 2'd1;
          end
          2'd1: begin
            r_green <= s_data;
            r_phase <= 2'd2;
          end
          default: begin
            r_phase <= 2'd0;
            if (w_eol) begin
              r_x <= '0;
              r_y <= w_eof ? '0 : r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        endcase
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= {w_luma, w_sof, w_eol, w_eof};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

`ifdef GRAY_STATS_EN
  logic [7:0] r_min;
  logic [7:0] r_max;

  // Dropped pixels still count: stats describe what the camera delivered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= 8'd0;
      r_max <= 8'd0;
    end else if (w_start_req) begin
      r_min <= 8'hFF;
      r_max <= 8'h00;
    end else if (w_pix) begin
      if (w_luma < r_min) r_min <= w_luma;
      if (w_luma > r_max) r_max <= w_luma;
    end
  end

  assign frame_min = r_min;
  assign frame_max = r_max;
`else
  // Statistics outputs are not built in this configuration
`endif

endmodule

// File: tb/tb_rgb_gray_ingest.sv
// Bench for rgb_gray_ingest: table vectors plus random frames against a queue-based pixel model.
module tb_rgb_gray_ingest;
  localparam int W = 5;
  localparam int H = 5;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       camera_en, m_valid, m_sof, m_eol, m_eof, busy, done, overflow;
  logic [7:0] m_data;
`ifdef GRAY_STATS_EN
  logic [7:0] frame_min, frame_max;
`endif

  rgb_gray_ingest #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .camera_en(camera_en),
    .s_valid(s_valid), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .done(done),
`ifdef GRAY_STATS_EN
    .frame_min(frame_min), .frame_max(frame_max),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random
  int dut_pops = 0;

  // Reference model: frame-level state, byte phase, pixel index, FIFO as a queue
  int st;             // 0 idle, 1 requesting, 2 draining
  int phase, pix, mr, mg, mmin, mmax;
  bit ovf;
  int q[$];           // entry = luma<<3 | sof<<2 | eol<<1 | eof

  typedef struct {
    logic [7:0] r, g, b, y;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int luma(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b + 128) / 256;
  endfunction

  task automatic model_reset();
    q.delete();
    st = 0; phase = 0; pix = 0; ovf = 0; mmin = 0; mmax = 0; mr = 0; mg = 0;
  endtask

  task automatic check_and_model();
    int y, e;
    bit popd, was_empty;
    chk("camera_en", 32'(camera_en), 32'(st == 1));
    chk("busy", 32'(busy), 32'(st != 0));
    chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
    chk("done", 32'(done), 32'(st == 2 && q.size() == 0));
    chk("overflow", 32'(overflow), 32'(ovf));
    if (q.size() > 0) begin
      chk("m_data", 32'(m_data), q[0] >> 3);
      chk("m_flags", 32'({m_sof, m_eol, m_eof}), q[0] & 7);
    end
`ifdef GRAY_STATS_EN
    if (st == 2 && q.size() == 0) begin
      chk("frame_min", 32'(frame_min), mmin);
      chk("frame_max", 32'(frame_max), mmax);
    end
`endif
    if (m_valid && m_ready) dut_pops++;
    was_empty = (q.size() == 0);
    popd = !was_empty && m_ready;
    if (popd) void'(q.pop_front());
    case (st)
      0: if (start) begin
        st = 1; phase = 0; pix = 0; ovf = 0; mmin = 255; mmax = 0;
      end
      1: if (s_valid) begin
        if (phase == 0) begin mr = int'(s_data); phase = 1; end
        else if (phase == 1) begin mg = int'(s_data); phase = 2; end
        else begin
          y = luma(mr, mg, int'(s_data));
          e = (y << 3) | (int'(pix == 0) << 2) | (int'(pix % W == W - 1) << 1)
              | int'(pix == W * H - 1);
          if (q.size() < D) q.push_back(e);
          else ovf = 1;
          if (y < mmin) mmin = y;
          if (y > mmax) mmax = y;
          phase = 0;
          if (pix == W * H - 1) st = 2;
          pix++;
        end
      end
      default: if (was_empty) st = 0;
    endcase
  endtask

  task automatic step();
    case (rdy_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      default: m_ready = ($urandom_range(0, 9) < 7);
    endcase
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      s_valid = 1'b0;
      s_data  = 8'hzz;
      step();
    end
    s_valid = 1'b1;
    s_data  = b;
    step();
    s_valid = 1'b0;
    s_data  = 8'hzz;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int maxgap, input bit white);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 3; c++)
        send_byte(white ? 8'hFF : 8'($urandom_range(0, 255)), $urandom_range(0, maxgap));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (st != 0 && n < 300) begin
      step();
      n++;
    end
    step();
    chk("idle_after_drain", 32'(busy), 32'd0);
  endtask

  initial begin
    tbl[0] = '{8'd255, 8'd255, 8'd255, 8'd255};
    tbl[1] = '{8'd255, 8'd0,   8'd0,   8'd77};
    tbl[2] = '{8'd0,   8'd255, 8'd0,   8'd149};
    tbl[3] = '{8'd0,   8'd0,   8'd255, 8'd29};
    tbl[4] = '{8'd0,   8'd0,   8'd0,   8'd0};
    tbl[5] = '{8'd10,  8'd20,  8'd30,  8'd18};
    tbl[6] = '{8'd128, 8'd128, 8'd128, 8'd128};
    tbl[7] = '{8'd1,   8'd2,   8'd3,   8'd2};
    tbl[8] = '{8'd200, 8'd100, 8'd50,  8'd124};
    tbl[9] = '{8'd12,  8'd34,  8'd56,  8'd30};

    model_reset();
    #12;
    chk("rst_camera_en", 32'(camera_en), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_flags", 32'({m_sof, m_eol, m_eof}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors at the head of a frame, checked one cycle after each B byte
    rdy_mode = 1;
    do_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(tbl[i].r, 0);
      send_byte(tbl[i].g, 0);
      send_byte(tbl[i].b, 0);
      chk("tbl_valid", 32'(m_valid), 1);
      chk("tbl_luma", 32'(m_data), 32'(tbl[i].y));
    end
    send_pixels(15, 2, 1'b0);
    wait_idle();

    // All-white frame, always ready
    do_start();
    send_pixels(25, 0, 1'b1);
    chk("white_camera_off", 32'(camera_en), 0);
    wait_idle();
    chk("white_no_ovf", 32'(overflow), 0);

    // Random data, random gaps, random backpressure
    for (int f = 0; f < 3; f++) begin
      rdy_mode = 2;
      do_start();
      send_pixels(25, (f == 0) ? 0 : 3, 1'b0);
      wait_idle();
    end

    // Downstream stalled for the whole frame
    rdy_mode = 0;
    do_start();
    send_pixels(25, 1, 1'b0);
    chk("stall_ovf", 32'(overflow), 1);
    chk("stall_full", 32'(m_valid), 1);
    dut_pops = 0;
    rdy_mode = 1;
    wait_idle();
    chk("stall_pops", 32'(dut_pops), 4);

    // Reset on byte 40, IDLE bytes, then a clean frame
    rdy_mode = 2;
    do_start();
    send_pixels(13, 1, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h5A;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_camera_en", 32'(camera_en), 0);
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    model_reset();
    s_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 0);
    chk("idle_bytes_no_out", 32'(m_valid), 0);
    rdy_mode = 1;
    do_start();
    send_byte(8'd255, 0);
    send_byte(8'd0, 0);
    send_byte(8'd0, 0);
    chk("post_rst_sof", 32'({m_valid, m_sof, m_data}), 32'({1'b1, 1'b1, 8'd77}));
    send_pixels(24, 1, 1'b0);
    wait_idle();

    // Gray pixels whose luma equals the byte value: 10, 200, 77 repeating
    do_start();
    for (int p = 0; p < 25; p++) begin
      logic [7:0] v;
      v = (p % 3 == 0) ? 8'd10 : ((p % 3 == 1) ? 8'd200 : 8'd77);
      for (int c = 0; c < 3; c++) send_byte(v, 0);
    end
    wait_idle();
`ifdef GRAY_STATS_EN
    chk("stats_min", 32'(frame_min), 10);
    chk("stats_max", 32'(frame_max), 200);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rgb_gray_ingest.md
Name: rgb_gray_ingest

Overview:
- Sits directly downstream of the frame byte source that emits interleaved R,G,B bytes with a valid strobe whenever its enable is high.
- Requests one frame by driving camera_en and groups every 3 valid bytes into a pixel.
- Converts each pixel to 8-bit luma and buffers it in a small FIFO.
- Presents the luma as a valid/ready stream with start-of-frame, end-of-line and end-of-frame markers.

Parameters:
- WIDTH, 5, pixels per line.
- HEIGHT, 5, lines per frame.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; requests one frame; ignored unless state is IDLE.
- camera_en  output  1  enable to the byte source; high only in state REQ.
- s_valid  input  1  input byte valid (the source's data_valid).
- s_data  input  8  input byte (R, then G, then B per pixel).
- m_valid  output  1  output luma valid.
- m_ready  input  1  downstream accept.
- m_data  output  8  luma value.
- m_sof  output  1  head entry is pixel (0,0).
- m_eol  output  1  head entry is the last pixel of a line.
- m_eof  output  1  head entry is the last pixel of the frame.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse when the frame is fully drained.
- overflow  output  1  sticky; a pixel was dropped because the FIFO was full.

Behaviour:
- Reset values: every output is 0 (camera_en, m_valid, m_data, m_sof, m_eol, m_eof, busy, done, overflow). FIFO is empty, all counters are 0, state is IDLE.
- IDLE:
  - start moves to REQ.
  - On entry to REQ, clear overflow, the byte phase, x and y.
- REQ:
  - camera_en = 1.
  - Sample s_data on each clk edge where s_valid = 1. s_data is don't-care when s_valid = 0, including Z.
  - Byte phase cycles 0, 1, 2: phase 0 latches R, phase 1 latches G.
  - At phase 2, Y = (77*R + 150*G + 29*B + 128) >> 8. Use a 16-bit unsigned sum; it cannot overflow and the result is 0..255.
  - At the same phase-2 edge, write {Y, sof, eol, eof} into the FIFO. m_valid rises the following cycle if the FIFO was empty, so latency is 1 cycle from the B-byte edge.
  - x increments per pixel and wraps at WIDTH-1, which increments y. sof = (x==0 && y==0); eol = (x==WIDTH-1); eof = eol && (y==HEIGHT-1).
  - After writing the eof pixel, go to DRAIN. camera_en falls on that same edge, so no further bytes are sampled.
- DRAIN:
  - camera_en = 0; s_valid is ignored.
  - When the FIFO is empty, pulse done for one cycle and return to IDLE.
- s_valid outside REQ is ignored and does not advance the phase.
- FIFO:
  - Standard first-word-fall-through. m_* fields reflect the head entry.
  - A pop occurs when m_valid && m_ready.
  - A simultaneous push and pop when full is legal: no drop, occupancy unchanged.
  - A push when full with no pop drops the pixel and sets overflow. x, y and phase still advance, so framing stays aligned.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy uses a counter or an extra pointer bit.
- Downstream stall: the byte source has no backpressure. Stalls longer than the FIFO capacity cause drops and are flagged, never stall the input.
- start while busy is ignored.
- Reset mid-frame (rst_n low at any time) forces IDLE immediately, drops camera_en asynchronously and flushes the FIFO.

Optional Feature:
- Macro: GRAY_STATS_EN.
- Defined:
  - Adds outputs frame_min[7:0] and frame_max[7:0].
  - Both are reset to 0; on REQ entry they load 8'hFF and 8'h00.
  - They update on every computed pixel, including dropped ones.
  - Both are stable from the done pulse until the next REQ entry.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- Frame of 25 pixels, all (255,255,255), m_ready = 1 -> 25 outputs of 8'hFF; camera_en low after the 75th byte; done one cycle after the last pop; overflow = 0.
- Pixels (255,0,0), (0,255,0), (0,0,255), (0,0,0) -> m_data 77, 149, 29, 0, each valid 1 cycle after its B byte.
- 5x5 frame -> m_sof only on pixel 0; m_eol on pixels 4, 9, 14, 19, 24; m_eof only on pixel 24.
- m_ready = 0 for the whole frame with FIFO_DEPTH = 4 -> first 4 pixels retained, overflow = 1. Releasing m_ready then pops 4 entries and done pulses.
- rst_n low on byte 40, then start again -> camera_en low immediately; FIFO empty; new frame sof on its first pixel with correct values; s_valid pulses in IDLE produce no output.
- With GRAY_STATS_EN: frame luma values {10, 200, 77} -> frame_min = 10, frame_max = 200 at done.
